// File: rtl/unified_buffer_arbiter.sv
// unified_buffer_arbiter: shares the single-ported unified buffer SRAM.
// Optional feature macro: UB_ARB_STARVE_GUARD_EN (starvation promotion).
module unified_buffer_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_req_i,
  output logic              rd_gnt_o,
  input  logic              rd_lock_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_rvalid_o,
  input  logic              wb_req_i,
  output logic              wb_gnt_o,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              host_req_i,
  output logic              host_gnt_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_rvalid_o,
  output logic              ub_en_o,
  output logic              ub_we_o,
  output logic [ADDR_W-1:0] ub_addr_o,
  output logic [DATA_W-1:0] ub_wdata_o,
  input  logic [DATA_W-1:0] ub_rdata_i,
  output logic [DATA_W-1:0] ub_rdata_o
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_lim_chk
    $error("STARVE_LIM must be within 1..15");
  end

  typedef enum logic {
    S_OPEN,
    S_LOCKED
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_open;
  logic w_rd_gnt;
  logic w_wb_gnt;
  logic w_host_gnt;
  logic w_wb_starved;
  logic w_host_starved;
  logic w_any;
  logic w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_tag_rd;
  logic              r_tag_host;
  logic              r_rv_rd;
  logic              r_rv_host;

  // A cycle with the lock released is arbitrated as OPEN even if
  // the register still says LOCKED.
  assign w_open = (r_state == S_OPEN) || !rd_lock_i;

`ifdef UB_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] r_wb_cnt;
  logic [3:0] r_host_cnt;

  // Saturating wait counters; they run in LOCKED too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb_cnt   <= '0;
      r_host_cnt <= '0;
    end else begin
      if (!wb_req_i || w_wb_gnt)
        r_wb_cnt <= '0;
      else if (r_wb_cnt != 4'hf)
        r_wb_cnt <= r_wb_cnt + 4'd1;
      if (!host_req_i || w_host_gnt)
        r_host_cnt <= '0;
      else if (r_host_cnt != 4'hf)
        r_host_cnt <= r_host_cnt + 4'd1;
    end
  end

  assign w_wb_starved   = (r_wb_cnt >= LIM);
  assign w_host_starved = (r_host_cnt >= LIM);
`else
  assign w_wb_starved   = 1'b0;
  assign w_host_starved = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_state <= S_OPEN;
    else
      r_state <= w_state_nxt;
  end

  // Next state: enter LOCKED on a locked rd grant, leave when lock drops.
  always_comb begin
    w_state_nxt = r_state;
    if (w_open)
      w_state_nxt = (w_rd_gnt && rd_lock_i) ? S_LOCKED : S_OPEN;
    else
      w_state_nxt = S_LOCKED;
  end

  // Grant outputs: starved wb > starved host > rd > wb > host.
  always_comb begin
    w_rd_gnt   = 1'b0;
    w_wb_gnt   = 1'b0;
    w_host_gnt = 1'b0;
    if (!rst_i) begin
      if (!w_open)
        w_rd_gnt = rd_req_i;
      else if (wb_req_i && w_wb_starved)
        w_wb_gnt = 1'b1;
      else if (host_req_i && w_host_starved)
        w_host_gnt = 1'b1;
      else if (rd_req_i)
        w_rd_gnt = 1'b1;
      else if (wb_req_i)
        w_wb_gnt = 1'b1;
      else if (host_req_i)
        w_host_gnt = 1'b1;
    end
  end

  assign w_any = w_rd_gnt | w_wb_gnt | w_host_gnt;
  assign w_we  = w_wb_gnt | (w_host_gnt & host_we_i);

  // Winner's address and write data.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    if (w_rd_gnt) begin
      w_addr = rd_addr_i;
    end else if (w_wb_gnt) begin
      w_addr  = wb_addr_i;
      w_wdata = wb_wdata_i;
    end else if (w_host_gnt) begin
      w_addr  = host_addr_i;
      w_wdata = host_wdata_i;
    end
  end

  // SRAM command register plus two-stage read tag pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tag_rd   <= 1'b0;
      r_tag_host <= 1'b0;
      r_rv_rd    <= 1'b0;
      r_rv_host  <= 1'b0;
    end else begin
      r_en       <= w_any;
      r_we       <= w_we;
      if (w_any)
        r_addr <= w_addr;
      if (w_we)
        r_wdata <= w_wdata;
      r_tag_rd   <= w_rd_gnt;
      r_tag_host <= w_host_gnt & ~host_we_i;
      r_rv_rd    <= r_tag_rd;
      r_rv_host  <= r_tag_host;
    end
  end

  assign rd_gnt_o      = w_rd_gnt;
  assign wb_gnt_o      = w_wb_gnt;
  assign host_gnt_o    = w_host_gnt;
  assign ub_en_o       = r_en;
  assign ub_we_o       = r_we;
  assign ub_addr_o     = r_addr;
  assign ub_wdata_o    = r_wdata;
  assign rd_rvalid_o   = r_rv_rd;
  assign host_rvalid_o = r_rv_host;
  assign ub_rdata_o    = ub_rdata_i;

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
// tb_unified_buffer_arbiter: scoreboard bench for unified_buffer_arbiter.
// Expectations follow UB_ARB_STARVE_GUARD_EN the same way as the design.
module tb_unified_buffer_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 256;
  localparam int LIM = 8;
`ifdef UB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 0, rd_lock = 0, wb_req = 0;
  logic          host_req = 0, host_we = 0;
  logic [AW-1:0] rd_addr = '0, wb_addr = '0, host_addr = '0;
  logic [DW-1:0] wb_wdata = '0, host_wdata = '0;
  logic          rd_gnt, wb_gnt, host_gnt;
  logic          rd_rv, host_rv;
  logic          ub_en, ub_we;
  logic [AW-1:0] ub_addr;
  logic [DW-1:0] ub_wdata, ub_rdata_i, ub_rdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    bit            host;
    logic [DW-1:0] data;
    int            cyc;
  } rdx_t;

  acc_t acc_q[$];
  rdx_t rd_q[$];

  logic [DW-1:0] sram [int];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] sram_q = '0;

  unified_buffer_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt),
    .rd_lock_i(rd_lock), .rd_addr_i(rd_addr),
    .rd_rvalid_o(rd_rv),
    .wb_req_i(wb_req), .wb_gnt_o(wb_gnt),
    .wb_addr_i(wb_addr), .wb_wdata_i(wb_wdata),
    .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rv),
    .ub_en_o(ub_en), .ub_we_o(ub_we),
    .ub_addr_o(ub_addr), .ub_wdata_o(ub_wdata),
    .ub_rdata_i(ub_rdata_i), .ub_rdata_o(ub_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1 + 32'h0000_1357;
    return {8{w}};
  endfunction

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (ub_en && ub_we)
      sram[int'(ub_addr)] = ub_wdata;
    if (ub_en && !ub_we)
      sram_q <= sram.exists(int'(ub_addr)) ?
                sram[int'(ub_addr)] : pat(int'(ub_addr));
  end
  assign ub_rdata_i = sram_q;

  // Scoreboard: check last cycle's access and due reads, then log grants.
  always @(negedge clk) begin
    acc_t a;
    rdx_t r;
    logic [DW-1:0] d;
    cyc_n++;
    if (acc_q.size() > 0) begin
      a = acc_q.pop_front();
      check("ub_en", DW'(ub_en), DW'(a.en));
      if (a.en) begin
        check("ub_we", DW'(ub_we), DW'(a.we));
        check("ub_addr", DW'(ub_addr), DW'(a.addr));
        if (a.we)
          check("ub_wdata", ub_wdata, a.wdata);
      end
    end
    if (rd_rv || host_rv) begin
      if (rd_q.size() == 0) begin
        check("rv_spurious", DW'({rd_rv, host_rv}), DW'(0));
      end else begin
        r = rd_q.pop_front();
        check("rv_src", DW'({rd_rv, host_rv}),
              DW'(r.host ? 2'b01 : 2'b10));
        check("rdata", ub_rdata, r.data);
        check("rlat", DW'(cyc_n - r.cyc), DW'(2));
      end
    end else if (rd_q.size() > 0 && cyc_n - rd_q[0].cyc >= 2) begin
      r = rd_q.pop_front();
      check("rv_missing", DW'(0), DW'(1));
    end
    check("gnt_onehot",
          DW'($countones({rd_gnt, wb_gnt, host_gnt}) <= 1), DW'(1));
    a = '{en: 1'b0, we: 1'b0, addr: '0, wdata: '0};
    if (rst) begin
      check("rst_gnt", DW'({rd_gnt, wb_gnt, host_gnt}), DW'(0));
      rd_q.delete();
    end else if (rd_req && rd_gnt) begin
      a.en = 1'b1;
      a.addr = rd_addr;
      d = ref_mem.exists(int'(rd_addr)) ?
          ref_mem[int'(rd_addr)] : pat(int'(rd_addr));
      rd_q.push_back('{host: 1'b0, data: d, cyc: cyc_n});
    end else if (wb_req && wb_gnt) begin
      a = '{en: 1'b1, we: 1'b1, addr: wb_addr, wdata: wb_wdata};
      ref_mem[int'(wb_addr)] = wb_wdata;
    end else if (host_req && host_gnt) begin
      a = '{en: 1'b1, we: host_we, addr: host_addr,
            wdata: host_wdata};
      if (host_we) begin
        ref_mem[int'(host_addr)] = host_wdata;
      end else begin
        d = ref_mem.exists(int'(host_addr)) ?
            ref_mem[int'(host_addr)] : pat(int'(host_addr));
        rd_q.push_back('{host: 1'b1, data: d, cyc: cyc_n});
      end
    end
    acc_q.push_back(a);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] exp);
    #1;
    check(tag, DW'({rd_gnt, wb_gnt, host_gnt}), DW'(exp));
  endtask

  task automatic chk_idle_outs(input string tag);
    check({tag, "_en"}, DW'(ub_en), DW'(0));
    check({tag, "_we"}, DW'(ub_we), DW'(0));
    check({tag, "_addr"}, DW'(ub_addr), DW'(0));
    check({tag, "_wdata"}, ub_wdata, DW'(0));
    check({tag, "_rv"}, DW'({rd_rv, host_rv}), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] va;
    logic ew, eh;
    va = {8{32'hA5A5_0010}};

    // Reset with everyone requesting.
    rd_req = 1; wb_req = 1; host_req = 1;
    chk_gnt("rst_all_req", 3'b000);
    step(); step();
    chk_idle_outs("rst");
    rd_req = 0; wb_req = 0; host_req = 0;
    rst = 0;
    step();

    // Host write 0x010 then host read 0x010.
    host_req = 1; host_we = 1; host_addr = 12'h010; host_wdata = va;
    chk_gnt("hw_gnt", 3'b001);
    step();
    host_we = 0;
    check("hw_ub_we", DW'({ub_en, ub_we}), DW'(2'b11));
    check("hw_ub_addr", DW'(ub_addr), DW'(12'h010));
    chk_gnt("hr_gnt", 3'b001);
    step();
    host_req = 0;
    step();
    check("hr_rvalid", DW'(host_rv), DW'(1));
    check("hr_rdata", ub_rdata, va);
    step();

    // All three request at once.
    rd_req = 1; rd_addr = 12'h020;
    wb_req = 1; wb_addr = 12'h030; wb_wdata = {8{32'hBEEF_0030}};
    host_req = 1; host_we = 0; host_addr = 12'h010;
    chk_gnt("all3_rd", 3'b100);
    step();
    rd_req = 0;
    chk_gnt("all3_wb", 3'b010);
    step();
    wb_req = 0;
    chk_gnt("all3_host", 3'b001);
    step();
    host_req = 0;
    step();

    // Continuous rd with wb held.
    rd_req = 1;
    wb_req = 1; wb_addr = 12'h040; wb_wdata = {8{32'hC0DE_0040}};
    for (int k = 1; k <= 12; k++) begin
      ew = GUARD && (k == LIM + 1);
      rd_addr = 12'(12'h200 + k);
      chk_gnt($sformatf("starve_wb_%0d", k), {~ew, ew, 1'b0});
      step();
      if (ew) wb_req = 0;
    end
    rd_req = 0;
    if (wb_req) begin
      chk_gnt("starve_wb_late", 3'b010);
      step();
      wb_req = 0;
    end
    step();

    // Locked 32-row rd burst with host waiting; one gap mid-burst.
    host_req = 1; host_we = 0; host_addr = 12'h040;
    rd_lock = 1;
    for (int i = 0, n = 0; i < 33; i++) begin
      if (i == 16) begin
        rd_req = 0;
        chk_gnt("burst_gap", 3'b000);
      end else begin
        rd_req = 1;
        rd_addr = 12'(12'h100 + n);
        n++;
        chk_gnt($sformatf("burst_%0d", i), 3'b100);
      end
      step();
    end
    rd_req = 0; rd_lock = 0;
    chk_gnt("burst_host", 3'b001);
    step();
    host_req = 0;
    step();

    // wb and host waiting together under continuous rd.
    rd_req = 1;
    wb_req = 1; wb_addr = 12'h050; wb_wdata = {8{32'h0BAD_0050}};
    host_req = 1; host_we = 0; host_addr = 12'h030;
    for (int k = 1; k <= 11; k++) begin
      ew = GUARD && (k == LIM + 1);
      eh = GUARD && (k == LIM + 2);
      rd_addr = 12'(12'h300 + k);
      chk_gnt($sformatf("both_%0d", k), {~(ew | eh), ew, eh});
      step();
      if (ew) wb_req = 0;
      if (eh) host_req = 0;
    end
    rd_req = 0;
    if (wb_req) begin
      chk_gnt("both_wb_late", 3'b010);
      step();
      wb_req = 0;
    end
    if (host_req) begin
      chk_gnt("both_host_late", 3'b001);
      step();
      host_req = 0;
    end
    step();

    // Reset right after a locked rd grant.
    rd_req = 1; rd_lock = 1; rd_addr = 12'h055;
    chk_gnt("prerst_rd", 3'b100);
    step();
    rd_req = 0; rst = 1;
    wb_req = 1; wb_addr = 12'h060; wb_wdata = {8{32'h6060_6060}};
    chk_gnt("inrst_gnt", 3'b000);
    step();
    chk_idle_outs("midrst");
    rst = 0;
    chk_gnt("postrst_open", 3'b010);
    step();
    wb_req = 0; rd_lock = 0;
    repeat (4) step();

    check("rd_q_empty", DW'(rd_q.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unified_buffer_arbiter.md
# unified_buffer_arbiter

Shares the single-ported unified buffer SRAM among three requesters: the activation read stream feeding the systolic array, the accumulator writeback path, and the host load/store port. One access per cycle; latency-critical activation reads win by default, with a starvation guard and a burst lock so a 32-row tile fetch is never interleaved. Sits between the unified buffer control logic and the SRAM macro.

## Interface
- ADDR_W, 12, unified buffer word address width
- DATA_W, 256, buffer word width (32 lanes x 8 bit)
- STARVE_LIM, 8, wait cycles after which a starved requester is promoted (range 1..15)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- rd_req_i / rd_gnt_o  in/out  1  activation read request / grant
- rd_lock_i  in  1  hold grant on rd while high (tile burst)
- rd_addr_i  in  ADDR_W  activation read address
- rd_rvalid_o  out  1  read data for rd valid on ub_rdata_o
- wb_req_i / wb_gnt_o  in/out  1  writeback write request / grant
- wb_addr_i, wb_wdata_i  in  ADDR_W, DATA_W  writeback address / data
- host_req_i / host_gnt_o  in/out  1  host request / grant
- host_we_i  in  1  1 = write, 0 = read
- host_addr_i, host_wdata_i  in  ADDR_W, DATA_W  host address / data
- host_rvalid_o  out  1  read data for host valid on ub_rdata_o
- ub_en_o, ub_we_o  out  1  SRAM enable / write enable (registered)
- ub_addr_o, ub_wdata_o  out  ADDR_W, DATA_W  SRAM address / write data (registered)
- ub_rdata_i  in  DATA_W  SRAM read data, 1 cycle after ub_en_o & !ub_we_o
- ub_rdata_o  out  DATA_W  ub_rdata_i passed through unregistered

## Operation
- Transfer occurs in cycle N when req & gnt; requester must hold req/addr/data stable until granted. At most one gnt high per cycle; gnt combinational from req, state, starvation flags.
- State OPEN: priority starved wb > starved host > rd > wb > host.
- OPEN -> LOCKED when rd granted with rd_lock_i = 1. LOCKED: rd_gnt_o = rd_req_i, wb/host gnt forced 0. LOCKED -> OPEN on first cycle rd_lock_i = 0 (that cycle already arbitrated as OPEN).
- Starvation counters (wb, host; 4 bit, saturating): +1 each cycle req & !gnt; cleared on gnt or req low. Flag starved = counter >= STARVE_LIM. Counters keep counting in LOCKED; promotion takes effect only in OPEN.
- Winner registered into ub_en_o/ub_we_o/ub_addr_o/ub_wdata_o at cycle N+1; ub_en_o = 0 on idle cycles, ub_wdata_o holds last value on reads.
- Read tag (rd/host) pipelined with the access; rd_rvalid_o or host_rvalid_o pulses in cycle N+2 together with valid ub_rdata_o. Writes produce no rvalid.

## Timing
- Reset: state OPEN, counters 0, all gnt 0 while rst_i high, ub_en_o = ub_we_o = 0, ub_addr_o = 0, ub_wdata_o = 0, both rvalid 0; in-flight read tags dropped (no rvalid after reset, even if issued the cycle before).
- Grant latency 0 when uncontended; read data latency 2 cycles from grant; write hits SRAM 1 cycle after grant.
- Throughput: one access per cycle, back-to-back grants to same or different requesters allowed.
- Simultaneous starvation of wb and host: wb wins, host counter keeps counting.
- rd_lock_i high without rd grant: ignored. rd_req_i low while LOCKED: no access, remain LOCKED.
- Worst-case wait for wb/host in OPEN with continuous rd traffic: STARVE_LIM cycles (+1 if other requester also starved).

## Configuration
- UB_ARB_STARVE_GUARD_EN defined: starvation counters and promotion as above.
- Not defined: counters removed, pure fixed priority rd > wb > host; wb/host may starve indefinitely under continuous rd.

## Test plan
- Single host write addr 0x010 data A, then host read 0x010 -> ub_we_o=1 at N+1; host_rvalid_o at read grant+2 with ub_rdata_o = A.
- rd, wb, host all requesting same cycle in OPEN, counters 0 -> rd_gnt_o only; wb then host granted in following cycles once rd drops.
- Continuous rd_req_i, wb_req_i held, guard enabled, STARVE_LIM=8 -> wb_gnt_o on 9th cycle of waiting, rd stalled that cycle; macro undefined -> wb never granted.
- rd burst 32 reads with rd_lock_i high, host requesting throughout -> 32 consecutive rd grants, no host grant until lock drops, then host granted immediately (starved).
- wb and host both starved simultaneously -> wb granted first, host next cycle.
- rst_i asserted one cycle after a rd grant -> no rd_rvalid_o, all outputs at reset values, state OPEN after release.
